mc_control: RTL and testbench

//  Multi-cycle main control FSM for the MIPS core; successor to the single-cycle opcode decoder.

---
 rtl/mc_control.sv | 168 ++++++++++++++++
 tb/tb_mc_control.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// Multi-cycle MIPS main control FSM: sequences each instruction through the
// FETCH/DECODE/EXEC/MEM/WB states and drives every datapath enable and mux select.
module mc_control #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit EN_ADDI       = 1'b1,
    parameter bit EN_JUMP       = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    state_t cur, nxt;
    logic   ready;

    assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) cur <= S_FETCH;
        else       cur <= nxt;
    end

    always_comb begin
        nxt           = S_FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        state         = cur;

        case (cur)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = ready;
                pc_write  = ready;
                nxt       = ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                if (opcode == OP_LW || opcode == OP_SW) nxt = S_MEMADR;
                else if (opcode == OP_RTYP)             nxt = S_EXEC;
                else if (opcode == OP_BEQ)              nxt = S_BRANCH;
                else if (EN_JUMP && opcode == OP_J)     nxt = S_JUMP;
                else if (EN_ADDI && opcode == OP_ADDI)  nxt = S_ADDIEX;
                else begin
                    nxt        = S_FETCH;
                    illegal_op = 1'b1;
                end
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                nxt      = ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                nxt       = ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                nxt       = S_RWB;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            default: nxt = S_FETCH;
        endcase

        // Reset forces every output low, so no write strobe can fire while reset is held.
        if (reset) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            iord          = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            pc_source     = 2'b00;
            illegal_op    = 1'b0;
            state         = 4'd0;
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Directed table-driven bench for mc_control: a default-parameter instance walks
// every instruction class, a second instance covers the reduced-feature configuration.
module tb_mc_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Control word: {pw,pwc,iord,mr,mw,irw,m2r,rd,rw,asa,asb[1:0],op[1:0],ps[1:0],ill}
    localparam logic [16:0] Z     = 17'd0;
    localparam logic [16:0] F_R   = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
    localparam logic [16:0] F_W   = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
    localparam logic [16:0] DEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0};
    localparam logic [16:0] DEC_I = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b1};
    localparam logic [16:0] MADR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
    localparam logic [16:0] MRD   = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] MWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] MWR   = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] EXE   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0};
    localparam logic [16:0] RWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
    localparam logic [16:0] BR    = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0};
    localparam logic [16:0] JMP   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0};
    localparam logic [16:0] AEX   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
    localparam logic [16:0] AWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] ctl;
    } vec_t;

    vec_t tv[$];
    int   errors = 0;
    int   checks = 0;

    // Default instance
    logic        reset, mem_ready;
    logic [5:0]  opcode;
    logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic [16:0] act;

    mc_control u0 (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .illegal_op(illegal_op)
    );
    assign act = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                  reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};

    // Reduced instance: no handshake, no addi, no jump
    logic        r_reset, r_mem_ready;
    logic [5:0]  r_opcode;
    logic        r_pc_write, r_pc_write_cond, r_iord, r_mem_read, r_mem_write, r_ir_write;
    logic        r_mem_to_reg, r_reg_dst, r_reg_write, r_alu_src_a, r_illegal_op;
    logic [1:0]  r_alu_src_b, r_alu_op, r_pc_source;
    logic [3:0]  r_state;
    logic [16:0] r_act;

    mc_control #(.MEM_HANDSHAKE(1'b0), .EN_ADDI(1'b0), .EN_JUMP(1'b0)) u1 (
        .clk(clk), .reset(r_reset), .opcode(r_opcode), .mem_ready(r_mem_ready),
        .pc_write(r_pc_write), .pc_write_cond(r_pc_write_cond), .iord(r_iord),
        .mem_read(r_mem_read), .mem_write(r_mem_write), .ir_write(r_ir_write),
        .mem_to_reg(r_mem_to_reg), .reg_dst(r_reg_dst), .reg_write(r_reg_write),
        .alu_src_a(r_alu_src_a), .alu_src_b(r_alu_src_b), .alu_op(r_alu_op),
        .pc_source(r_pc_source), .state(r_state), .illegal_op(r_illegal_op)
    );
    assign r_act = {r_pc_write, r_pc_write_cond, r_iord, r_mem_read, r_mem_write, r_ir_write,
                    r_mem_to_reg, r_reg_dst, r_reg_write, r_alu_src_a, r_alu_src_b, r_alu_op,
                    r_pc_source, r_illegal_op};

    task automatic add(input logic rst, input logic [5:0] op, input logic rdy,
                       input logic [3:0] st, input logic [16:0] ctl);
        vec_t v;
        v.rst = rst; v.op = op; v.rdy = rdy; v.st = st; v.ctl = ctl;
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input logic [16:0] got, input logic [16:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        reset = 1'b1; opcode = '0; mem_ready = 1'b0;
        r_reset = 1'b1; r_opcode = '0; r_mem_ready = 1'b0;

        // reset, then lw with no stalls: states 0,1,2,3,4
        add(1, 6'b000000, 0, 4'd0, Z);
        add(1, 6'b000000, 0, 4'd0, Z);
        add(0, 6'b100011, 1, 4'd0, F_R);
        add(0, 6'b100011, 1, 4'd1, DEC);
        add(0, 6'b100011, 1, 4'd2, MADR);
        add(0, 6'b100011, 1, 4'd3, MRD);
        add(0, 6'b100011, 1, 4'd4, MWB);
        // sw with mem_ready low 2 cycles in MEMWR
        add(0, 6'b101011, 1, 4'd0, F_R);
        add(0, 6'b101011, 1, 4'd1, DEC);
        add(0, 6'b101011, 1, 4'd2, MADR);
        add(0, 6'b101011, 0, 4'd5, MWR);
        add(0, 6'b101011, 0, 4'd5, MWR);
        add(0, 6'b101011, 1, 4'd5, MWR);
        // FETCH stalled 4 cycles, then R-type
        add(0, 6'b000000, 0, 4'd0, F_W);
        add(0, 6'b000000, 0, 4'd0, F_W);
        add(0, 6'b000000, 0, 4'd0, F_W);
        add(0, 6'b000000, 0, 4'd0, F_W);
        add(0, 6'b000000, 1, 4'd0, F_R);
        add(0, 6'b000000, 1, 4'd1, DEC);
        add(0, 6'b000000, 1, 4'd6, EXE);
        add(0, 6'b000000, 1, 4'd7, RWB);
        // beq
        add(0, 6'b000100, 1, 4'd0, F_R);
        add(0, 6'b000100, 1, 4'd1, DEC);
        add(0, 6'b000100, 1, 4'd8, BR);
        // j
        add(0, 6'b000010, 1, 4'd0, F_R);
        add(0, 6'b000010, 1, 4'd1, DEC);
        add(0, 6'b000010, 1, 4'd9, JMP);
        // addi
        add(0, 6'b001000, 1, 4'd0, F_R);
        add(0, 6'b001000, 1, 4'd1, DEC);
        add(0, 6'b001000, 1, 4'd10, AEX);
        add(0, 6'b001000, 1, 4'd11, AWB);
        // lw aborted by a 3-cycle reset while stalled in MEMRD
        add(0, 6'b100011, 1, 4'd0, F_R);
        add(0, 6'b100011, 1, 4'd1, DEC);
        add(0, 6'b100011, 1, 4'd2, MADR);
        add(0, 6'b100011, 0, 4'd3, MRD);
        add(1, 6'b100011, 1, 4'd0, Z);
        add(1, 6'b100011, 1, 4'd0, Z);
        add(1, 6'b100011, 1, 4'd0, Z);
        // unknown opcode: 2-cycle illegal path
        add(0, 6'b111111, 1, 4'd0, F_R);
        add(0, 6'b111111, 1, 4'd1, DEC_I);
        add(0, 6'b111111, 0, 4'd0, F_W);

        foreach (tv[i]) begin
            @(negedge clk);
            reset = tv[i].rst; opcode = tv[i].op; mem_ready = tv[i].rdy;
            #1;
            chk($sformatf("vec%0d state", i), {13'd0, state}, {13'd0, tv[i].st});
            chk($sformatf("vec%0d ctl", i), act, tv[i].ctl);
        end

        // Reduced configuration: mem_ready held low throughout
        @(negedge clk); r_reset = 1'b1; r_mem_ready = 1'b0; r_opcode = 6'b001000;
        @(negedge clk); r_reset = 1'b0;
        #1;
        chk("nohs fetch ctl", r_act, F_R);
        chk("nohs fetch state", {13'd0, r_state}, 17'd0);
        @(negedge clk); #1;
        chk("addi_off decode ctl", r_act, DEC_I);
        chk("addi_off decode state", {13'd0, r_state}, 17'd1);
        @(negedge clk); #1;
        chk("addi_off back to fetch", {13'd0, r_state}, 17'd0);
        chk("addi_off no reg_write", {16'd0, r_reg_write}, 17'd0);
        chk("addi_off fetch ctl", r_act, F_R);
        r_opcode = 6'b000010;
        @(negedge clk); #1;
        chk("j_off decode ctl", r_act, DEC_I);
        @(negedge clk); #1;
        chk("j_off back to fetch", {13'd0, r_state}, 17'd0);
        r_opcode = 6'b100011;
        @(negedge clk); #1;
        chk("nohs lw decode", {13'd0, r_state}, 17'd1);
        @(negedge clk); #1;
        chk("nohs lw memadr", {13'd0, r_state}, 17'd2);
        @(negedge clk); #1;
        chk("nohs lw memrd ctl", r_act, MRD);
        @(negedge clk); #1;
        chk("nohs lw memwb ctl", r_act, MWB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
